drive_mode_sequencer: RTL
=========================

DRIVE_MODE_SEQUENCER -- requirements
Module: drive_mode_sequencer

Interface
REQ-001 SHALL have parameter DEADTIME, default 8'd100: cycles of motor-off between direction-control clients.
REQ-002 SHALL have parameter TIMEOUT, default 24'd10_000_000: maximum unpaused RUN cycles per client.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 Start  input  1  mission start, rising-edge detected internally.
REQ-007 Pause  input  1  level; freezes motion and counters.
REQ-008 Abort  input  1  level; forces FAULT.
REQ-009 ModeMask  input  3  participating clients (bit i = client i), sampled on accepted Start.
REQ-010 ClientDone  input  3  per-client completion level/pulse.
REQ-011 ClientDutyA / ClientDutyB  input  6 each  client i duty at [2i+1:2i].
REQ-012 ClientDir  input  12  client i {FWDA,FWDB,BWDA,BWDB} at [4i+3:4i].
REQ-013 ClientEnable  output  3  one-cycle start pulse to selected client.
REQ-014 DutyCycleA, DutyCycleB  output  2 each; FWDA, FWDB, BWDA, BWDB  output  1 each: motor command to PWM/H-bridge.
REQ-015 Active  output  2  current client index, 2'b11 = none.
REQ-016 Busy  output  1; Done  output  1 (one-cycle pulse); Fault  output  2 (00 none, 01 timeout, 10 shoot-through, 11 abort).

Function
REQ-017 Start edge = Start & ~Start_q, Start_q registered each cycle.
REQ-018 States SHALL be IDLE, DEAD, ARM, RUN, PAUSED, COMPLETE, FAULT; all outputs registered.
REQ-019 IDLE: on Start edge with ModeMask!=0 latch mask, Fault<=00, idx<=lowest set bit, go DEAD; with ModeMask==0 go COMPLETE.
REQ-020 DEAD: motor outputs zero; count DEADTIME unpaused cycles (counter holds while Pause=1), then ARM; DEADTIME=0 goes to ARM next cycle.
REQ-021 ARM: ClientEnable[idx]=1 for exactly one cycle, timeout counter cleared, go RUN.
REQ-022 RUN: motor outputs = client idx's inputs with one-cycle latency; timeout counter increments each cycle.
REQ-023 RUN event priority per cycle: Abort > shoot-through (FWDA&BWDA or FWDB&BWDB of client idx) > ClientDone[idx] > counter==TIMEOUT-1 > Pause.
REQ-024 RUN ClientDone[idx]: clear mask bit idx; remaining mask!=0 -> idx<=next lowest set bit, DEAD; else COMPLETE.
REQ-025 ClientDone of non-active clients SHALL be ignored in all states.
REQ-026 PAUSED: motor outputs zero, timeout counter frozen; Pause=0 returns to RUN without new ClientEnable pulse.
REQ-027 Abort=1 in DEAD, ARM, RUN or PAUSED -> FAULT code 11 next cycle; Abort ignored in IDLE, COMPLETE, FAULT.
REQ-028 Timeout -> FAULT code 01; shoot-through -> FAULT code 10; shoot-through command never reaches outputs (outputs zero that cycle).
REQ-029 COMPLETE: Done=1 one cycle, motor outputs zero, return to IDLE.
REQ-030 FAULT: motor outputs zero, Fault held; Start edge behaves as in IDLE (clears Fault).
REQ-031 Start edge while Busy SHALL be ignored.
REQ-032 Busy=1 in DEAD, ARM, RUN, PAUSED; Active=idx in those states, else 2'b11.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, all motor outputs 0, ClientEnable 0, Done 0, Busy 0, Fault 00, Active 2'b11, counters and Start_q 0, latched mask 0.
REQ-034 Reset mid-RUN SHALL drop motor outputs to zero asynchronously with no ClientEnable or Done emitted.

Verification (bench DEADTIME=4, TIMEOUT=20)
REQ-035 ModeMask=101, Start rise, each client asserts Done 5 cycles after enable -> Enable pulses 001 then 100, 4 zero cycles before each, Active 0 then 2, single Done pulse, Fault 00.
REQ-036 ModeMask=010, client 1 never Done -> Fault=01 after 20 RUN cycles, outputs zero, Busy 0.
REQ-037 Client 0 drives ClientDir 4'b1010 in RUN -> Fault=10, FWDA/BWDA never both 1 at outputs.
REQ-038 Pause 10 cycles mid-RUN, client Done after 25 total cycles (15 unpaused) -> no timeout, no second Enable, outputs zero during pause.
REQ-039 Abort in DEAD -> Fault=11; subsequent Start with ModeMask=001 -> Fault cleared, client 0 enabled after 4 cycles.
REQ-040 ModeMask=000 Start -> Done pulse within 2 cycles, no ClientEnable.

Source files
------------

// File: rtl/drive_mode_sequencer.sv
// drive_mode_sequencer
//
// Runs up to three motor-direction clients one after another. After an
// accepted Start rising edge the selected clients (ModeMask) are served
// lowest index first: a dead-time gap with the motor off, a one-cycle enable
// pulse to the client, then RUN, where the client's duty/direction request is
// forwarded to the motor outputs one cycle late. RUN ends on the client's
// done, on timeout, on a shoot-through request, or on Abort.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   Start                  mission start (rising edge used)
//   Pause                  level, freezes motion and counters
//   Abort                  level, forces FAULT code 11 while busy
//   ModeMask[2:0]          participating clients, sampled on accepted Start
//   ClientDone[2:0]        per-client completion
//   ClientDutyA/B[5:0]     client i duty at [2i+1:2i]
//   ClientDir[11:0]        client i {FWDA,FWDB,BWDA,BWDB} at [4i+3:4i]
//   ClientEnable[2:0]      one-cycle start pulse to the selected client
//   DutyCycleA/B[1:0], FWDA, FWDB, BWDA, BWDB   motor command
//   Active[1:0]            current client, 2'b11 when not busy
//   Busy, Done (pulse), Fault[1:0] (00 none, 01 timeout, 10 shoot-through, 11 abort)
module drive_mode_sequencer #(
    parameter logic [7:0]  DEADTIME = 8'd100,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Pause,
    input  logic        Abort,
    input  logic [2:0]  ModeMask,
    input  logic [2:0]  ClientDone,
    input  logic [5:0]  ClientDutyA,
    input  logic [5:0]  ClientDutyB,
    input  logic [11:0] ClientDir,
    output logic [2:0]  ClientEnable,
    output logic [1:0]  DutyCycleA,
    output logic [1:0]  DutyCycleB,
    output logic        FWDA,
    output logic        FWDB,
    output logic        BWDA,
    output logic        BWDB,
    output logic [1:0]  Active,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  Fault
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DEAD, ST_ARM, ST_RUN, ST_PAUSED, ST_COMPLETE, ST_FAULT
    } state_t;

    state_t      state_reg;
    logic        start_q_reg;
    logic [2:0]  mask_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  dead_cnt_reg;
    logic [23:0] tmo_cnt_reg;

    // Per-client slices; entry 3 exists so a 2-bit index never leaves the array.
    logic [1:0] duty_a_arr [4];
    logic [1:0] duty_b_arr [4];
    logic [3:0] dir_arr    [4];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_client
            assign duty_a_arr[gi] = ClientDutyA[2*gi+1 -: 2];
            assign duty_b_arr[gi] = ClientDutyB[2*gi+1 -: 2];
            assign dir_arr[gi]    = ClientDir[4*gi+3 -: 4];
        end
    endgenerate
    assign duty_a_arr[3] = 2'b00;
    assign duty_b_arr[3] = 2'b00;
    assign dir_arr[3]    = 4'b0000;

    logic [1:0] sel_duty_a;
    logic [1:0] sel_duty_b;
    logic [3:0] sel_dir;
    logic       sel_done;
    logic [3:0] done_pad;
    logic       shoot;
    logic       start_edge;
    logic [2:0] mask_left;
    logic       fault_hit;
    logic [1:0] fault_code;

    assign done_pad   = {1'b0, ClientDone};
    assign sel_duty_a = duty_a_arr[idx_reg];
    assign sel_duty_b = duty_b_arr[idx_reg];
    assign sel_dir    = dir_arr[idx_reg];
    assign sel_done   = done_pad[idx_reg];
    // Both legs of the same half-bridge requested at once.
    assign shoot      = (sel_dir[3] & sel_dir[1]) | (sel_dir[2] & sel_dir[0]);
    assign start_edge = Start & ~start_q_reg;
    assign mask_left  = mask_reg & ~(3'b001 << idx_reg);

    function automatic logic [1:0] lowest_client(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Fault conditions in priority order; done outranks the timeout.
    always_comb begin
        fault_hit  = 1'b0;
        fault_code = 2'b00;
        case (state_reg)
            ST_DEAD, ST_ARM, ST_PAUSED: begin
                if (Abort) begin
                    fault_hit  = 1'b1;
                    fault_code = 2'b11;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    fault_hit  = 1'b1;
                    fault_code = 2'b11;
                end else if (shoot) begin
                    fault_hit  = 1'b1;
                    fault_code = 2'b10;
                end else if (!sel_done && tmo_cnt_reg == TIMEOUT - 24'd1) begin
                    fault_hit  = 1'b1;
                    fault_code = 2'b01;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            start_q_reg  <= 1'b0;
            mask_reg     <= 3'b000;
            idx_reg      <= 2'd0;
            dead_cnt_reg <= 8'd0;
            tmo_cnt_reg  <= 24'd0;
            ClientEnable <= 3'b000;
            DutyCycleA   <= 2'b00;
            DutyCycleB   <= 2'b00;
            FWDA         <= 1'b0;
            FWDB         <= 1'b0;
            BWDA         <= 1'b0;
            BWDB         <= 1'b0;
            Active       <= 2'b11;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Fault        <= 2'b00;
        end else begin
            start_q_reg  <= Start;
            // Pulses and motor command default to off; only a clean RUN
            // cycle forwards the client request.
            ClientEnable <= 3'b000;
            Done         <= 1'b0;
            DutyCycleA   <= 2'b00;
            DutyCycleB   <= 2'b00;
            FWDA         <= 1'b0;
            FWDB         <= 1'b0;
            BWDA         <= 1'b0;
            BWDB         <= 1'b0;

            if (fault_hit) begin
                state_reg <= ST_FAULT;
                Fault     <= fault_code;
                Busy      <= 1'b0;
                Active    <= 2'b11;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_FAULT: begin
                        if (start_edge) begin
                            Fault <= 2'b00;
                            if (ModeMask != 3'b000) begin
                                mask_reg     <= ModeMask;
                                idx_reg      <= lowest_client(ModeMask);
                                Active       <= lowest_client(ModeMask);
                                dead_cnt_reg <= 8'd0;
                                Busy         <= 1'b1;
                                state_reg    <= ST_DEAD;
                            end else begin
                                Done      <= 1'b1;
                                state_reg <= ST_COMPLETE;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (!Pause) begin
                            if (DEADTIME == 8'd0 || dead_cnt_reg == DEADTIME - 8'd1) begin
                                ClientEnable <= 3'b001 << idx_reg;
                                state_reg    <= ST_ARM;
                            end else begin
                                dead_cnt_reg <= dead_cnt_reg + 8'd1;
                            end
                        end
                    end
                    ST_ARM: begin
                        tmo_cnt_reg <= 24'd0;
                        state_reg   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (sel_done) begin
                            mask_reg <= mask_left;
                            if (mask_left != 3'b000) begin
                                idx_reg      <= lowest_client(mask_left);
                                Active       <= lowest_client(mask_left);
                                dead_cnt_reg <= 8'd0;
                                state_reg    <= ST_DEAD;
                            end else begin
                                Done      <= 1'b1;
                                Busy      <= 1'b0;
                                Active    <= 2'b11;
                                state_reg <= ST_COMPLETE;
                            end
                        end else if (Pause) begin
                            state_reg <= ST_PAUSED;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 24'd1;
                            DutyCycleA  <= sel_duty_a;
                            DutyCycleB  <= sel_duty_b;
                            FWDA        <= sel_dir[3];
                            FWDB        <= sel_dir[2];
                            BWDA        <= sel_dir[1];
                            BWDB        <= sel_dir[0];
                        end
                    end
                    ST_PAUSED: begin
                        // Resume without re-enabling the client.
                        if (!Pause) state_reg <= ST_RUN;
                    end
                    ST_COMPLETE: state_reg <= ST_IDLE;
                    default:     state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
